// File: rtl/history_dump_streamer_if.sv
// Output stream of the history dump: one history entry per valid/ready transfer.
interface history_dump_streamer_if #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 4
) ();
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data, out_idx, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_idx, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/history_dump_streamer.sv
// Freezes a snapshot of the debug history array on trigger and streams it
// newest-first over a valid/ready interface to the trace sink.
//
// state  | meaning
// IDLE   | waiting for trigger; out_valid low
// STREAM | snapshot frozen, presenting snap[idx] until the last transfer
module history_dump_streamer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      history_in [DEPTH],
  input  logic                  trigger,
  input  logic [IDXW:0]         dump_len,
  history_dump_streamer_if.master dump,
  output logic                  busy,
  output logic                  done,
  output logic                  trig_dropped,
  input  logic                  clear_flags
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDXW:0] DEPTH_W = (IDXW+1)'(DEPTH);
  localparam logic [IDXW:0] ONE_W   = (IDXW+1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] snap [DEPTH];
  logic [IDXW:0]    len_reg;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  idx_nxt;
  logic [IDXW:0]    len_eff;
  logic             start, advance, finish;

  // Zero or oversize lengths mean "dump the whole history".
  assign len_eff = (dump_len == '0 || dump_len > DEPTH_W) ? DEPTH_W : dump_len;
  assign idx_nxt = idx + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; the stream only moves on an accepted transfer.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          start   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (dump.out_valid && dump.out_ready) begin
          if (dump.out_last) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot, index and registered stream outputs; outputs never look at
  // out_ready combinationally, so they hold steady while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) snap[i] <= '0;
      len_reg        <= '0;
      idx            <= '0;
      dump.out_data  <= '0;
      dump.out_idx   <= '0;
      dump.out_valid <= 1'b0;
      dump.out_last  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= finish;
      if (start) begin
        snap           <= history_in;
        len_reg        <= len_eff;
        idx            <= '0;
        dump.out_data  <= history_in[0];
        dump.out_idx   <= '0;
        dump.out_valid <= 1'b1;
        dump.out_last  <= (len_eff == ONE_W);
        busy           <= 1'b1;
      end else if (advance) begin
        idx            <= idx_nxt;
        dump.out_data  <= snap[idx_nxt];
        dump.out_idx   <= idx_nxt;
        dump.out_last  <= ({1'b0, idx_nxt} == len_reg - ONE_W);
      end else if (finish) begin
        dump.out_valid <= 1'b0;
        dump.out_last  <= 1'b0;
        busy           <= 1'b0;
      end
    end
  end

  // Sticky dropped-trigger flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    trig_dropped <= 1'b0;
    else if (trigger && busy)   trig_dropped <= 1'b1;
    else if (clear_flags)       trig_dropped <= 1'b0;
  end

endmodule

// File: doc/history_dump_streamer.md
Name: history_dump_streamer

Overview:
- Reads a snapshot of the per-cycle signal history array produced by the pipeline debug capture shift register.
- Streams the snapshot out one entry per transfer over a valid/ready interface, newest entry first, to the debug/trace sink (UART bridge or testbench monitor).
- The snapshot is frozen at trigger, so the live history keeps shifting while the dump proceeds.

Parameters:
- WIDTH, 8, bit width of each history entry.
- DEPTH, 16, number of history entries; must be ≥2.
- IDXW, $clog2(DEPTH), width of the entry index and length fields.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- history_in  input  WIDTH x [0:DEPTH-1]  live history array; index 0 = newest.
- trigger  input  1  start-dump request, sampled on rising clk.
- dump_len  input  IDXW+1  number of entries to send, latched at trigger; 0 or >DEPTH means DEPTH.
- out_data  output  WIDTH  current entry.
- out_idx  output  IDXW  history index of out_data.
- out_valid  output  1  entry available.
- out_ready  input  1  sink accepts entry.
- out_last  output  1  final entry of dump.
- busy  output  1  dump in progress.
- done  output  1  one-cycle pulse after the final transfer.
- trig_dropped  output  1  sticky flag: a trigger arrived while busy.
- clear_flags  input  1  synchronous clear of trig_dropped.

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - Snapshot registers, index and length registers clear to 0.
  - Reset mid-dump aborts the dump immediately, with no done pulse.
- FSM states are IDLE and STREAM.
- IDLE:
  - trigger=1 at edge N copies every history_in[i] into snap[i].
  - The same edge latches the effective length L into len_reg (dump_len clamped per the dump_len rule) and sets idx=0.
  - It also sets out_data=history_in[0], out_idx=0, out_valid=1, busy=1, and out_last=(L==1), then enters STREAM.
  - Latency: first entry is valid in the cycle following the trigger edge.
- STREAM:
  - Transfer occurs on an edge with out_valid&&out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable (no combinational dependence on out_ready).
  - On a transfer with idx<L-1: idx increments, out_data=snap[idx+1], out_idx=idx+1, out_last=(idx+1==L-1).
  - This allows back-to-back transfers, one per cycle when out_ready is held high.
  - On a transfer with out_last=1: out_valid=0, busy=0, out_last=0, done=1 for exactly one cycle, then return to IDLE.
- Snapshot is immutable during STREAM; history_in changes do not affect the streamed data.
- Triggers:
  - trigger while busy=1 is ignored for data and sets trig_dropped=1.
  - A trigger in the same cycle as the final transfer is also dropped and flagged.
  - A new dump may start at the earliest on the edge after done is asserted, i.e. while done=1.
- clear_flags=1 clears trig_dropped. If a dropped trigger occurs in the same cycle, set wins.
- out_valid never deasserts without a transfer except via reset.
- Index arithmetic is IDXW-bit unsigned; idx never exceeds L-1, so there is no wrap-around.

Test Plan:
- Full dump: WIDTH=8, DEPTH=16, history_in[i]=8'h10+i, dump_len=0, out_ready=1, trigger 1 cycle -> 16 consecutive beats, out_data 10h..1Fh, out_idx 0..15, out_last only on beat 16, done pulses 1 cycle after, busy low.
- Snapshot freeze: trigger, then change all history_in to 8'hFF during the stream -> streamed data remains 10h..1Fh.
- Backpressure and short length: dump_len=3, out_ready toggling 1,0,0,1,0,1 -> exactly 3 beats (10h,11h,12h); data and out_last stable while stalled; out_last on third beat.
- Dropped trigger: trigger again mid-dump -> stream unaffected and trig_dropped=1; clear_flags pulse -> trig_dropped=0; clear_flags coincident with a new busy trigger -> trig_dropped stays 1.
- Reset mid-dump: assert rst asynchronously at beat 5 -> out_valid, busy and out_last drop immediately, no done; after release, a trigger produces a fresh dump starting at out_idx=0.
- Length boundaries: dump_len=1 -> single beat with out_last=1. dump_len=17 -> 16 beats.
